// File: rtl/spi_ram_arbiter.sv
// Bridges the SPI slave command stream and a local host onto one single-port RAM.
// SPI commands update address latches or queue one RAM access; the host and SPI share the RAM round-robin.
module spi_ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [7:0]        i_host_wdata,
  output logic              o_host_gnt,
  output logic [7:0]        o_host_rdata,
  output logic              o_host_rvalid,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata,
  output logic              o_spi_busy,
  output logic              o_err_ovf
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          w_op;
  logic [DATA_W-1:0]   w_payload;
  logic [ADDR_W-1:0]   w_payload_addr;
  logic                w_cmd_ram;
  logic                w_spi_cand;
  logic                w_host_cand;
  logic                w_spi_sel;
  logic                w_host_sel;
  logic                w_any_sel;
  logic                w_accept;
  logic                w_drop;

  logic                r_slot_vld;
  logic                r_slot_rd;
  logic [ADDR_W-1:0]   r_slot_addr;
  logic [DATA_W-1:0]   r_slot_data;

  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_rd_addr;

  logic                r_last_host;
  logic                r_acc_host;
  logic                r_acc_we;
  logic [ADDR_W-1:0]   r_acc_addr;
  logic [DATA_W-1:0]   r_acc_wdata;

  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_valid;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                r_host_rvalid;
  logic                r_err_ovf;

  assign w_op           = i_rx_data[9:8];
  assign w_payload      = i_rx_data[7:0];
  assign w_payload_addr = i_rx_data[ADDR_W-1:0];
  assign w_cmd_ram      = i_rx_valid & w_op[0];

  // Round-robin: on a tie the requester that did not own the RAM last wins.
  assign w_spi_cand  = (r_state == S_IDLE) & r_slot_vld;
  assign w_host_cand = (r_state == S_IDLE) & i_host_req;
  assign w_spi_sel   = w_spi_cand  & (~w_host_cand | r_last_host);
  assign w_host_sel  = w_host_cand & (~w_spi_cand  | ~r_last_host);
  assign w_any_sel   = w_spi_sel | w_host_sel;

  // A slot being handed to the RAM this cycle can be refilled in the same edge.
  assign w_accept = w_cmd_ram & (~r_slot_vld | w_spi_sel);
  assign w_drop   = w_cmd_ram & ~w_accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else if (i_rx_valid) begin
      case (w_op)
        2'b00:   r_wr_addr <= w_payload_addr;
        2'b01:   if (w_accept && AUTO_INC) r_wr_addr <= r_wr_addr + ADDR_W'(1);
        2'b10:   r_rd_addr <= w_payload_addr;
        default: if (w_accept && AUTO_INC) r_rd_addr <= r_rd_addr + ADDR_W'(1);
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot_vld <= 1'b0;
    end else if (w_accept) begin
      r_slot_vld <= 1'b1;
    end else if (w_spi_sel) begin
      r_slot_vld <= 1'b0;
    end
  end

  // Address is snapshotted here so later latch writes cannot retarget a queued access.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_slot_rd   <= w_op[1];
      r_slot_addr <= w_op[1] ? r_rd_addr : r_wr_addr;
      r_slot_data <= w_payload;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_sel) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = r_acc_we ? S_IDLE : S_RDWAIT;
      S_RDWAIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_host_gnt  = 1'b0;
    if (r_state == S_ACCESS) begin
      o_ram_en    = 1'b1;
      o_ram_we    = r_acc_we;
      o_ram_addr  = r_acc_addr;
      o_ram_wdata = r_acc_we ? r_acc_wdata : '0;
      o_host_gnt  = r_acc_host;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_host <= 1'b1;
      r_acc_host  <= 1'b0;
      r_acc_we    <= 1'b0;
    end else if (w_any_sel) begin
      r_last_host <= w_host_sel;
      r_acc_host  <= w_host_sel;
      r_acc_we    <= w_host_sel ? i_host_we : ~r_slot_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_any_sel) begin
      r_acc_addr  <= w_host_sel ? i_host_addr  : r_slot_addr;
      r_acc_wdata <= w_host_sel ? i_host_wdata : r_slot_data;
    end
  end

  // RAM read data lands during RDWAIT; the owner sees a registered strobe one cycle later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_valid    <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_tx_data     <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_tx_valid    <= (r_state == S_RDWAIT) & ~r_acc_host;
      r_host_rvalid <= (r_state == S_RDWAIT) &  r_acc_host;
      if (r_state == S_RDWAIT) begin
        if (r_acc_host) begin
          r_host_rdata <= i_ram_rdata;
        end else begin
          r_tx_data <= i_ram_rdata;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_ovf <= 1'b0;
    end else if (w_drop) begin
      r_err_ovf <= 1'b1;
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = r_tx_valid;
  assign o_host_rdata  = r_host_rdata;
  assign o_host_rvalid = r_host_rvalid;
  assign o_spi_busy    = r_slot_vld;
  assign o_err_ovf     = r_err_ovf;

endmodule
